// File: rtl/sap_control_sequencer_pkg.sv
// sap_ctrl_pkg: opcodes, one-hot T-state encodings and the control word shared by the SAP-1 sequencer.
package sap_ctrl_pkg;
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_JMP = 4'h3;
   localparam logic [3:0] OP_JC  = 4'h4;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;
   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;
   typedef struct packed {
      logic pc_inc;
      logic pc_out;
      logic pc_load;
      logic mar_load;
      logic ram_out;
      logic ir_load;
      logic ir_out;
      logic a_load;
      logic a_out;
      logic b_load;
      logic out_load;
      logic alu_en;
      logic alu_sum;
      logic alu_tx;
      logic alu_cin;
      logic halt;
   } ctrl_word_t;
endpackage

// File: rtl/sap_control_sequencer_if.sv
// sap_control_sequencer_if: opcode/carry inputs and the full control word between sequencer and datapath.
interface sap_control_sequencer_if #(parameter int OP_W = 4, parameter int T_W = 6);
   logic [OP_W-1:0] ir_opcode;
   logic            alu_cout;
   logic [T_W-1:0]  t_state;
   logic pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out, a_load;
   logic a_out, b_load, out_load, alu_en, alu_sum, alu_tx, alu_cin, halt;
   modport master (
      input  ir_opcode, alu_cout,
      output t_state, pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out, a_load,
             a_out, b_load, out_load, alu_en, alu_sum, alu_tx, alu_cin, halt
   );
   modport slave (
      output ir_opcode, alu_cout,
      input  t_state, pc_inc, pc_out, pc_load, mar_load, ram_out, ir_load, ir_out, a_load,
             a_out, b_load, out_load, alu_en, alu_sum, alu_tx, alu_cin, halt
   );
endinterface

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: one-hot T-state ring with hold and asynchronous active-low clear to T1.
module sap_ring_counter #(parameter int T_W = 6) (
   input  logic           clk,
   input  logic           clr_n,
   input  logic           hold,
   output logic [T_W-1:0] t_state
);
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) t_state <= T_W'(1);
      else if (!hold) t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP-1 T-state ring plus opcode decode into the datapath control word.
// Defining SAP_JUMP_EN adds a carry flag and the JMP/JC instructions.
import sap_ctrl_pkg::*;
module sap_control_sequencer #(parameter int OP_W = 4, parameter int T_W = 6) (
   input logic clk,
   input logic clr_n,
   sap_control_sequencer_if.master bus
);
   logic [T_W-1:0]  t_state;
   logic [OP_W-1:0] op;
   logic            halted, hlt_t4, mem_op, arith;
   ctrl_word_t      cw, cw_q;
   assign op     = bus.ir_opcode;
   assign hlt_t4 = t_state == T4 && op == OP_HLT;
   assign mem_op = op inside {OP_LDA, OP_ADD, OP_SUB};
   assign arith  = op inside {OP_ADD, OP_SUB};
   sap_ring_counter #(.T_W(T_W)) u_ring (.clk(clk), .clr_n(clr_n), .hold(halted | hlt_t4), .t_state(t_state));
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) halted <= 1'b0;
      else if (hlt_t4) halted <= 1'b1;
`ifdef SAP_JUMP_EN
   logic carry;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) carry <= 1'b0;
      else if (t_state == T6 && arith) carry <= bus.alu_cout;
`else
   logic unused_cout;
   assign unused_cout = bus.alu_cout;
`endif
   always_comb begin
      cw = '0;
      if (halted || hlt_t4) cw.halt = 1'b1;
      else if (t_state == T1) begin
         cw.pc_out   = 1'b1;
         cw.mar_load = 1'b1;
      end else if (t_state == T2) cw.pc_inc = 1'b1;
      else if (t_state == T3) begin
         cw.ram_out = 1'b1;
         cw.ir_load = 1'b1;
      end else if (t_state == T4) begin
         if (mem_op) begin
            cw.ir_out   = 1'b1;
            cw.mar_load = 1'b1;
         end else if (op == OP_OUT) begin
            cw.a_out    = 1'b1;
            cw.out_load = 1'b1;
         end
`ifdef SAP_JUMP_EN
         else if (op == OP_JMP || op == OP_JC) begin
            cw.ir_out  = 1'b1;
            cw.pc_load = op == OP_JMP || carry;
         end
`endif
      end else if (t_state == T5 && mem_op) begin
         cw.ram_out = 1'b1;
         cw.a_load  = op == OP_LDA;
         cw.b_load  = op != OP_LDA;
      end else if (t_state == T6 && arith) begin
         cw.alu_en  = 1'b1;
         cw.alu_sum = op == OP_ADD;
         cw.a_load  = 1'b1;
      end
   end
   // Reset holds the ring at T1, so the word is masked to keep the bus quiet during clear.
   assign cw_q = clr_n ? cw : '0;
   assign bus.t_state  = t_state;
   assign bus.pc_inc   = cw_q.pc_inc;
   assign bus.pc_out   = cw_q.pc_out;
   assign bus.pc_load  = cw_q.pc_load;
   assign bus.mar_load = cw_q.mar_load;
   assign bus.ram_out  = cw_q.ram_out;
   assign bus.ir_load  = cw_q.ir_load;
   assign bus.ir_out   = cw_q.ir_out;
   assign bus.a_load   = cw_q.a_load;
   assign bus.a_out    = cw_q.a_out;
   assign bus.b_load   = cw_q.b_load;
   assign bus.out_load = cw_q.out_load;
   assign bus.alu_en   = cw_q.alu_en;
   assign bus.alu_sum  = cw_q.alu_sum;
   assign bus.alu_tx   = cw_q.alu_tx;
   assign bus.alu_cin  = cw_q.alu_cin;
   assign bus.halt     = cw_q.halt;
   bus_single_driver: assert property (@(posedge clk) disable iff (!clr_n)
      $onehot0({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_en}));
endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: directed instruction sequences with a queued scoreboard checked by a per-cycle monitor.
module tb_sap_control_sequencer;
   import sap_ctrl_pkg::*;
   typedef struct {
      string      name;
      logic [5:0] t;
      ctrl_word_t w;
   } exp_t;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   sap_control_sequencer_if bus ();
   sap_control_sequencer dut (.clk(clk), .clr_n(clr_n), .bus(bus));
   exp_t sb[$];
   exp_t e;
   int total = 0;
   int passed = 0;
   ctrl_word_t act, z, c_t1, c_t2, c_t3, c_mem4, c_lda5, c_ar5, c_add6, c_sub6, c_out4, c_halt, c_jc1, c_jc0;
   always #5 clk = ~clk;
   initial forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         act = {bus.pc_inc, bus.pc_out, bus.pc_load, bus.mar_load, bus.ram_out, bus.ir_load,
                bus.ir_out, bus.a_load, bus.a_out, bus.b_load, bus.out_load, bus.alu_en,
                bus.alu_sum, bus.alu_tx, bus.alu_cin, bus.halt};
         total++;
         if (act === e.w && bus.t_state === e.t) passed++;
         else $display("FAIL %s: got t_state=%b cw=%h, expected t_state=%b cw=%h", e.name, bus.t_state, act, e.t, e.w);
         total++;
         if ($onehot0({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_en})) passed++;
         else $display("FAIL %s_bus: drivers=%b, expected at most one", e.name,
                       {bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_en});
      end
   end
   task automatic cyc(input string nm, input logic rn, input logic [3:0] op, input logic cout,
                      input int ti, input ctrl_word_t w);
      exp_t x;
      @(posedge clk);
      #1;
      clr_n = rn;
      bus.ir_opcode = op;
      bus.alu_cout = cout;
      x.name = $sformatf("%s_T%0d", nm, ti);
      x.t = 6'(1 << (ti - 1));
      x.w = w;
      sb.push_back(x);
   endtask
   task automatic fetch(input string nm, input logic [3:0] op, input logic cout);
      cyc(nm, 1'b1, op, cout, 1, c_t1);
      cyc(nm, 1'b1, op, cout, 2, c_t2);
      cyc(nm, 1'b1, op, cout, 3, c_t3);
   endtask
   task automatic instr(input string nm, input logic [3:0] op, input logic cout,
                        input ctrl_word_t w4, input ctrl_word_t w5, input ctrl_word_t w6);
      fetch(nm, op, cout);
      cyc(nm, 1'b1, op, cout, 4, w4);
      cyc(nm, 1'b1, op, cout, 5, w5);
      cyc(nm, 1'b1, op, cout, 6, w6);
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      z = '0;
      c_t1 = z;   c_t1.pc_out = 1'b1;   c_t1.mar_load = 1'b1;
      c_t2 = z;   c_t2.pc_inc = 1'b1;
      c_t3 = z;   c_t3.ram_out = 1'b1;  c_t3.ir_load = 1'b1;
      c_mem4 = z; c_mem4.ir_out = 1'b1; c_mem4.mar_load = 1'b1;
      c_lda5 = z; c_lda5.ram_out = 1'b1; c_lda5.a_load = 1'b1;
      c_ar5 = z;  c_ar5.ram_out = 1'b1; c_ar5.b_load = 1'b1;
      c_add6 = z; c_add6.alu_en = 1'b1; c_add6.alu_sum = 1'b1; c_add6.a_load = 1'b1;
      c_sub6 = z; c_sub6.alu_en = 1'b1; c_sub6.a_load = 1'b1;
      c_out4 = z; c_out4.a_out = 1'b1;  c_out4.out_load = 1'b1;
      c_halt = z; c_halt.halt = 1'b1;
`ifdef SAP_JUMP_EN
      c_jc1 = z;  c_jc1.ir_out = 1'b1;  c_jc1.pc_load = 1'b1;
      c_jc0 = z;  c_jc0.ir_out = 1'b1;
`else
      c_jc1 = z;
      c_jc0 = z;
`endif
      bus.ir_opcode = OP_LDA;
      bus.alu_cout = 1'b0;
      repeat (3) cyc("RST", 1'b0, OP_LDA, 1'b0, 1, z);
      instr("LDA", OP_LDA, 1'b0, c_mem4, c_lda5, z);
      instr("ADD", OP_ADD, 1'b1, c_mem4, c_ar5, c_add6);
      instr("SUB", OP_SUB, 1'b0, c_mem4, c_ar5, c_sub6);
      instr("OUT", OP_OUT, 1'b0, c_out4, z, z);
      instr("NOP7", 4'h7, 1'b0, z, z, z);
      instr("ADDC", OP_ADD, 1'b1, c_mem4, c_ar5, c_add6);
      instr("JC_TAKEN", OP_JC, 1'b0, c_jc1, z, z);
      instr("SUBNC", OP_SUB, 1'b0, c_mem4, c_ar5, c_sub6);
      instr("JC_NOT", OP_JC, 1'b0, c_jc0, z, z);
      instr("JMP", OP_JMP, 1'b0, c_jc1, z, z);
      fetch("ADDR", OP_ADD, 1'b0);
      cyc("ADDR", 1'b1, OP_ADD, 1'b0, 4, c_mem4);
      cyc("MIDRST", 1'b0, OP_ADD, 1'b0, 1, z);
      cyc("MIDRST", 1'b0, OP_ADD, 1'b0, 1, z);
      instr("ADD_RESTART", OP_ADD, 1'b0, c_mem4, c_ar5, c_add6);
      fetch("HLT", OP_HLT, 1'b0);
      cyc("HLT", 1'b1, OP_HLT, 1'b0, 4, c_halt);
      repeat (20) cyc("HLT_HOLD", 1'b1, OP_ADD, 1'b1, 4, c_halt);
      cyc("HLT_CLR", 1'b0, OP_LDA, 1'b0, 1, z);
      instr("LDA_AFTER", OP_LDA, 1'b0, c_mem4, c_lda5, z);
      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control sequencer for the SAP-1 datapath: program counter, MAR, RAM, instruction register (IR), accumulator A, B register, adder/subtractor and output register.
- A 6-state one-hot ring counter (T1..T6) runs fetch and execute for each instruction.
- In every T-state the block decodes the ring counter and the IR opcode into a control word that drives the bus enables, register loads and ALU controls.
- Sits between the IR opcode field and all datapath control pins; it is the only bus-arbitration source.

Parameters:
- OP_W, 4, width of the opcode field taken from IR[7:4].
- T_W, 6, number of T-states, which is also the one-hot ring width; fixed at 6, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- ir_opcode  in  OP_W  upper nibble of the IR; valid from T4 onward.
- alu_cout  in  1  carry out of the adder/subtractor.
- t_state  out  T_W  one-hot ring; bit0 = T1.
- pc_inc  out  1  program counter increment.
- pc_out  out  1  program counter drives the bus.
- pc_load  out  1  program counter loads from the bus.
- mar_load  out  1  MAR loads from the bus.
- ram_out  out  1  RAM drives the bus.
- ir_load  out  1  IR loads from the bus.
- ir_out  out  1  IR operand nibble drives the bus.
- a_load  out  1  accumulator A loads.
- a_out  out  1  accumulator A drives the bus.
- b_load  out  1  B register loads.
- out_load  out  1  output register loads.
- alu_en  out  1  ALU drives the bus.
- alu_sum  out  1  1 = add, 0 = subtract.
- alu_tx  out  1  ALU passes B through; always 0.
- alu_cin  out  1  ALU carry in; always 0.
- halt  out  1  clock-stop request.

Behaviour:
- Clock and reset: one clock, clk. clr_n is asynchronous and active-low.
- Reset values:
  - t_state = 6'b000001 (T1).
  - halted flag = 0.
  - While clr_n = 0, every control output is forced to 0, including halt.
- Control word:
  - Purely combinational from t_state, ir_opcode and the halted flag.
  - Asserted for the whole cycle and sampled by the datapath on the next rising edge.
- Ring counter:
  - Advances T1→T2→…→T6→T1 on each rising edge.
  - Frozen while halted.
- Fetch (same for all opcodes):
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute (opcode constants from the package):
  - LDA (0x0): T4 ir_out, mar_load. T5 ram_out, a_load. T6 no control asserted.
  - ADD (0x1): T4 ir_out, mar_load. T5 ram_out, b_load. T6 alu_en, alu_sum=1, a_load.
  - SUB (0x2): same as ADD, but T6 has alu_sum=0.
  - OUT (0xE): T4 a_out, out_load. T5 and T6 no control asserted.
  - HLT (0xF):
    - At T4, the halted flag sets on the clock edge.
    - halt is asserted combinationally during T4 and held from then on.
    - The ring stays at T4 and no other control is asserted.
    - Only clr_n clears the halted flag.
  - Any other opcode: T4..T6 assert no control (NOP).
- Bus rule: at most one bus driver among pc_out, ram_out, ir_out, a_out, alu_en in any state; checked by an assertion.
- Reset mid-instruction: immediate return to T1 with all outputs 0. On the first edge after release, the ring is still T1 and the fetch restarts.

Optional Feature:
- Macro: SAP_JUMP_EN.
- When defined:
  - A carry flag register, reset 0, captures alu_cout at the T6 edge of ADD and SUB.
  - JMP (0x3): T4 ir_out, pc_load.
  - JC (0x4): T4 ir_out, plus pc_load only if the carry flag = 1.
  - For both, T5 and T6 assert no control.
- When undefined: no carry register, alu_cout ignored, pc_load tied 0, and 0x3/0x4 decode as NOP.

Decomposition:
- Package sap_ctrl_pkg holds:
  - opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JC, OP_OUT, OP_HLT);
  - one-hot T-state constants;
  - a packed control-word struct typedef.
- One sub-module, sap_ring_counter: 6-bit one-hot ring with a hold input and asynchronous active-low clear.
- Decode logic stays in the top level.

Test Plan:
- Reset: clr_n low for 3 cycles → t_state = 000001, all controls 0. After release → T1 word (pc_out=1, mar_load=1).
- LDA, ir_opcode = 0x0 → sequence T1..T6 with T5 ram_out=1, a_load=1; T6 all controls 0; back to T1.
- ADD 0x1 then SUB 0x2 → T6 alu_en=1 and a_load=1 in both; alu_sum = 1 for ADD, 0 for SUB; bus one-hot check passes in every cycle.
- HLT 0xF → halt=1 at T4; t_state remains 001000 for 20 cycles. Pulsing clr_n → halt=0 and t_state = T1.
- Mid-instruction reset: clr_n low at ADD T5 → outputs 0 immediately; restart at T1, no b_load.
- With SAP_JUMP_EN: ADD with alu_cout=1, then JC 0x4 → pc_load=1 at T4. Then SUB with alu_cout=0, then JC → pc_load=0. JMP 0x3 → pc_load=1 unconditionally.
